uart_rx_fifo_param: RTL

//  Parametrised UART receiver: configurable data bits, parity and stop bits, plus a

---
 rtl/uart_rx_fifo_param.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo_param.sv
// rtl/uart_rx_fifo_param.sv - parametrised oversampling UART receiver with FWFT receive FIFO
module uart_rx_fifo_param #(
    parameter int CLK_DIV    = 325,
    parameter int OVERSAMPLE = 16,
    parameter int DBITS      = 8,
    parameter int SBITS      = 1,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx,
    input  logic             rd_en,
    input  logic             clear_err,
    output logic [DBITS-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);

    localparam int TW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW   = $clog2(OVERSAMPLE);
    localparam int BW   = $clog2(DBITS);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int HALF = OVERSAMPLE / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t            state, state_n;
    logic              rx_meta, rxs;
    logic [TW-1:0]     tick_cnt;
    logic              tick;
    logic [SW-1:0]     s_cnt, s_cnt_n;
    logic [BW-1:0]     bit_idx, bit_n;
    logic              stop_idx, stop_n;
    logic [DBITS-1:0]  shreg, shreg_n;
    logic              push_n, push_q;
    logic              pe_set, fe_set;
    logic              bit_end;

    logic [DBITS-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              do_pop, do_write;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Held at zero while idle so every frame's sampling phase starts from its own start edge.
    assign tick = (state != S_IDLE) && (tick_cnt == TW'(CLK_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset || state == S_IDLE || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign bit_end = tick && (s_cnt == SW'(OVERSAMPLE - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            s_cnt    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            push_q   <= 1'b0;
        end else begin
            state    <= state_n;
            s_cnt    <= s_cnt_n;
            bit_idx  <= bit_n;
            stop_idx <= stop_n;
            shreg    <= shreg_n;
            push_q   <= push_n;
        end
    end

    always_comb begin
        state_n = state;
        s_cnt_n = s_cnt;
        bit_n   = bit_idx;
        stop_n  = stop_idx;
        shreg_n = shreg;
        push_n  = 1'b0;
        pe_set  = 1'b0;
        fe_set  = 1'b0;
        if (tick && !bit_end && state != S_START) begin
            s_cnt_n = s_cnt + SW'(1);
        end
        case (state)
            S_IDLE: begin
                if (!rxs) begin
                    state_n = S_START;
                    s_cnt_n = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (s_cnt == SW'(HALF - 1)) begin
                        s_cnt_n = '0;
                        if (rxs) begin
                            state_n = S_IDLE;
                        end else begin
                            state_n = S_DATA;
                            bit_n   = '0;
                        end
                    end else begin
                        s_cnt_n = s_cnt + SW'(1);
                    end
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    s_cnt_n          = '0;
                    shreg_n[bit_idx] = rxs;
                    if (bit_idx == BW'(DBITS - 1)) begin
                        state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                        stop_n  = 1'b0;
                    end else begin
                        bit_n = bit_idx + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    s_cnt_n = '0;
                    pe_set  = ((^shreg) ^ rxs) != (PARITY == 1);
                    state_n = S_STOP;
                    stop_n  = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    s_cnt_n = '0;
                    if (!rxs) begin
                        fe_set  = 1'b1;
                        state_n = S_BREAK;
                    end else if (stop_idx == 1'(SBITS - 1)) begin
                        push_n  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        stop_n = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                if (rxs) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // A pop against an empty FIFO is ignored; a full FIFO still accepts a push if it pops the same cycle.
    assign do_pop   = rd_en && !empty;
    assign do_write = push_q && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_write, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign data_out = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= pe_set | (parity_err & ~clear_err);
            frame_err  <= fe_set | (frame_err & ~clear_err);
            overrun    <= (push_q && full && !rd_en) | (overrun & ~clear_err);
        end
    end

endmodule
